ip_send: RTL

- IPv4 transmit framer: the transmit counterpart of the IP receive path.
- Takes a 32-bit payload word stream, for example from the UDP or TCP transmit logic, plus per-packet length, protocol and destination address.
- Emits a 20-byte IPv4 header (no options) with a computed header checksum, followed by the payload, as a 32-bit word stream for the MAC/framing layer.
- Payload is back-pressured with a ready signal while the header is generated.

---
 rtl/ip_send.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ip_send.sv
// ip_send: IPv4 transmit framer.
// Emits a 20-byte IPv4 header (no options, checksum computed over 3 cycles),
// then streams the payload words with trailing-byte masking on the last word.
// Optional feature macro: IP_SEND_ID_INC_EN (identification increments per
// completed packet; otherwise the identification field is constant zero).
module ip_send #(
  parameter logic [31:0] SRC_IP      = 32'hc0a80102,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [15:0] tx_len,
  input  logic [7:0]  tx_proto,
  input  logic [31:0] tx_dst_ip,
  output logic        tx_busy,
  output logic        len_err,
  input  logic        pl_valid,
  input  logic [31:0] pl_data,
  output logic        pl_ready,
  output logic        ip_valid_out,
  output logic [31:0] ip_data_out,
  output logic        ip_last_out
);

  typedef enum logic [1:0] {IDLE, CSUM, HDR, DATA} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic [15:0] total_len;
  logic [15:0] rem;
  logic [15:0] id;
  logic [15:0] csum_acc;
  logic [15:0] csum;
  logic [7:0]  proto;
  logic [31:0] dst;
  logic [1:0]  tail;
  logic [31:0] pl_reg;
  logic        pl_reg_valid;
  logic        pl_reg_last;
  logic        len_err_r;

  logic        len_ok;
  logic        start_ok;
  logic        start_bad;
  logic        accept;
  logic        last_out;

  // One's-complement add: 17-bit sum folded back with end-around carry
  function automatic logic [15:0] add1c(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Zero the bytes beyond the packet length in the final payload word
  function automatic logic [31:0] mask_tail(input logic [31:0] w, input logic [1:0] t);
    logic [31:0] m;
    case (t)
      2'd1:    m = 32'hff00_0000;
      2'd2:    m = 32'hffff_0000;
      2'd3:    m = 32'hffff_ff00;
      default: m = 32'hffff_ffff;
    endcase
    return w & m;
  endfunction

  assign len_ok    = (tx_len != 16'd0) && (tx_len <= MAX_PAYLOAD);
  assign start_ok  = tx_start && (state == IDLE) && len_ok;
  assign start_bad = tx_start && (state == IDLE) && !len_ok;
  assign accept    = pl_valid && pl_ready;
  assign last_out  = (state == DATA) && pl_reg_valid && pl_reg_last;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_ok)      state_nx = CSUM;
      CSUM: if (cnt == 3'd2)   state_nx = HDR;
      HDR:  if (cnt == 3'd4)   state_nx = DATA;
      DATA: if (last_out)      state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Per-state cycle counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || state_nx != state) cnt <= '0;
    else                                             cnt <= cnt + 3'd1;
  end

  // Packet datapath: request latch, checksum pipeline, payload register, id
  always_ff @(posedge clk) begin
    if (reset) begin
      total_len    <= '0;
      rem          <= '0;
      id           <= '0;
      csum_acc     <= '0;
      csum         <= '0;
      proto        <= '0;
      dst          <= '0;
      tail         <= '0;
      pl_reg       <= '0;
      pl_reg_valid <= 1'b0;
      pl_reg_last  <= 1'b0;
      len_err_r    <= 1'b0;
    end else begin
      len_err_r    <= start_bad;
      pl_reg_valid <= 1'b0;
      pl_reg_last  <= 1'b0;
      if (start_ok) begin
        total_len <= tx_len + 16'd20;
        rem       <= 16'(tx_len + 16'd3) >> 2;
        tail      <= tx_len[1:0];
        proto     <= tx_proto;
        dst       <= tx_dst_ip;
      end
      // Header checksum spread over the three CSUM cycles, 3-4 halfwords each
      if (state == CSUM) begin
        case (cnt)
          3'd0: csum_acc <= add1c(add1c(add1c(16'h4500, total_len), id), 16'h4000);
          3'd1: csum_acc <= add1c(add1c(add1c(csum_acc, {TTL, proto}), 16'h0000),
                                  SRC_IP[31:16]);
          3'd2: csum     <= ~add1c(add1c(add1c(csum_acc, SRC_IP[15:0]), dst[31:16]),
                                   dst[15:0]);
          default: ;
        endcase
      end
      if (accept) begin
        pl_reg_valid <= 1'b1;
        pl_reg_last  <= (rem == 16'd1);
        pl_reg       <= (rem == 16'd1) ? mask_tail(pl_data, tail) : pl_data;
        rem          <= rem - 16'd1;
      end
`ifdef IP_SEND_ID_INC_EN
      if (last_out) id <= id + 16'd1;
`endif
    end
  end

  // Output decode from state, header counter and payload register
  always_comb begin
    tx_busy      = (state != IDLE);
    len_err      = len_err_r;
    pl_ready     = 1'b0;
    ip_valid_out = 1'b0;
    ip_data_out  = '0;
    ip_last_out  = 1'b0;
    case (state)
      HDR: begin
        ip_valid_out = 1'b1;
        case (cnt)
          3'd0:    ip_data_out = {8'h45, 8'h00, total_len};
          3'd1:    ip_data_out = {id, 16'h4000};
          3'd2:    ip_data_out = {TTL, proto, csum};
          3'd3:    ip_data_out = SRC_IP;
          3'd4:    ip_data_out = dst;
          default: ip_data_out = '0;
        endcase
      end
      DATA: begin
        pl_ready     = (rem != 16'd0);
        ip_valid_out = pl_reg_valid;
        ip_data_out  = pl_reg;
        ip_last_out  = pl_reg_valid && pl_reg_last;
      end
      default: ;
    endcase
  end

endmodule
